// File: rtl/rv_imm_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : rv_imm_pkg
//  Description : Shared RV32I immediate definitions: format codes and the
//                signed range limits of every immediate format.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv_imm_pkg;

    // Format codes, identical to the ones used by the immediate decode path.
    // Codes 3'b110 and 3'b111 are reserved.
    typedef enum logic [2:0] {
        FMT_I       = 3'b000,
        FMT_I_SHAMT = 3'b001,
        FMT_S       = 3'b010,
        FMT_B       = 3'b011,
        FMT_J       = 3'b100,
        FMT_U       = 3'b101
    } imm_fmt_e;

    // 12-bit signed immediates (I, S).
    localparam logic signed [31:0] c_imm12_min = -32'sd2048;
    localparam logic signed [31:0] c_imm12_max =  32'sd2047;
    // 13-bit branch offsets; bit 0 is implicit so the maximum is even.
    localparam logic signed [31:0] c_imm13_min = -32'sd4096;
    localparam logic signed [31:0] c_imm13_max =  32'sd4094;
    // 21-bit jump offsets; bit 0 is implicit so the maximum is even.
    localparam logic signed [31:0] c_imm21_min = -32'sd1048576;
    localparam logic signed [31:0] c_imm21_max =  32'sd1048574;

endpackage : rv_imm_pkg
`default_nettype wire

// File: rtl/imm_encoder_if.sv
`default_nettype none
// ============================================================================
//  Interface   : imm_encoder_if
//  Description : Input and output streams of the immediate encoder.
//                Signal directions in the names are seen from the encoder.
//  Ports       : input side  i_valid/o_ready, i_base, i_imm, i_fmt, i_flush
//                output side o_valid/i_ready, o_instr, o_addr, o_err,
//                            o_err_sticky
//  Revision    : 1.0 - initial release
// ============================================================================
interface imm_encoder_if #(
    parameter int ADDR_W = 32
);
    logic              i_valid;
    logic              o_ready;
    logic [31:0]       i_base;
    logic [31:0]       i_imm;
    logic [2:0]        i_fmt;
    logic              i_flush;
    logic              o_valid;
    logic              i_ready;
    logic [31:0]       o_instr;
    logic [ADDR_W-1:0] o_addr;
    logic              o_err;
    logic              o_err_sticky;

    // Encoder side.
    modport slave (
        input  i_valid, i_base, i_imm, i_fmt, i_flush, i_ready,
        output o_ready, o_valid, o_instr, o_addr, o_err, o_err_sticky
    );

    // Producer / consumer side.
    modport master (
        output i_valid, i_base, i_imm, i_fmt, i_flush, i_ready,
        input  o_ready, o_valid, o_instr, o_addr, o_err, o_err_sticky
    );
endinterface : imm_encoder_if
`default_nettype wire

// File: rtl/imm_encoder_scatter.sv
`default_nettype none
// ============================================================================
//  Module      : imm_scatter
//  Description : Combinational RV32I immediate scatter. Produces the bit mask
//                of the format's immediate positions, the immediate bits
//                placed in those positions, and a range/format error flag.
//  Ports       : i_fmt   format code (see rv_imm_pkg::imm_fmt_e)
//                i_imm   two's complement immediate
//                o_mask  1 where the instruction bit belongs to the immediate
//                o_value scattered immediate, zero outside o_mask
//                o_err   immediate does not fit or format is reserved
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_scatter
    import rv_imm_pkg::*;
(
    input  wire logic [2:0]  i_fmt,
    input  wire logic [31:0] i_imm,
    output logic      [31:0] o_mask,
    output logic      [31:0] o_value,
    output logic             o_err
);

    logic signed [31:0] w_simm;
    assign w_simm = $signed(i_imm);

    always_comb begin
        o_mask  = 32'h0000_0000;
        o_value = 32'h0000_0000;
        o_err   = 1'b0;
        case (i_fmt)
            FMT_I: begin
                o_mask  = 32'hFFF0_0000;
                o_value = {i_imm[11:0], 20'b0};
                o_err   = (w_simm < c_imm12_min) || (w_simm > c_imm12_max);
            end
            FMT_I_SHAMT: begin
                // funct7 in [31:25] stays with the base word.
                o_mask  = 32'h01F0_0000;
                o_value = {7'b0, i_imm[4:0], 20'b0};
                o_err   = (i_imm[31:5] != 27'b0);
            end
            FMT_S: begin
                o_mask  = 32'hFE00_0F80;
                o_value = {i_imm[11:5], 13'b0, i_imm[4:0], 7'b0};
                o_err   = (w_simm < c_imm12_min) || (w_simm > c_imm12_max);
            end
            FMT_B: begin
                o_mask  = 32'hFE00_0F80;
                o_value = {i_imm[12], i_imm[10:5], 13'b0,
                           i_imm[4:1], i_imm[11], 7'b0};
                o_err   = (w_simm < c_imm13_min) || (w_simm > c_imm13_max)
                          || i_imm[0];
            end
            FMT_J: begin
                o_mask  = 32'hFFFF_F000;
                o_value = {i_imm[20], i_imm[10:1], i_imm[11],
                           i_imm[19:12], 12'b0};
                o_err   = (w_simm < c_imm21_min) || (w_simm > c_imm21_max)
                          || i_imm[0];
            end
            FMT_U: begin
                o_mask  = 32'hFFFF_F000;
                o_value = {i_imm[31:12], 12'b0};
                o_err   = (i_imm[11:0] != 12'b0);
            end
            default: begin
                // Reserved codes: flag the beat but still fill as I-type so
                // the emitted word is deterministic.
                o_mask  = 32'hFFF0_0000;
                o_value = {i_imm[11:0], 20'b0};
                o_err   = 1'b1;
            end
        endcase
    end

endmodule : imm_scatter
`default_nettype wire

// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : imm_encoder
//  Description : Streaming RV32I immediate encoder. Merges a scattered
//                immediate into a base instruction word, flags out-of-range
//                immediates and tags each emitted word with a running byte
//                address. Two register stages, valid/ready on both sides.
//  Ports       : i_clk   clock, rising edge
//                i_reset synchronous active-high reset (priority over flush)
//                bus     imm_encoder_if.slave - input beat, flush, output
//                        beat with address, error and sticky error
//  Parameters  : ADDR_W    width of the address counter
//                BASE_ADDR address of the first word, 4-byte aligned
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_encoder
    import rv_imm_pkg::*;
#(
    parameter int              ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
)(
    input  wire logic      i_clk,
    input  wire logic      i_reset,
    imm_encoder_if.slave   bus
);

    // Pipeline advances whenever the output register is empty or drained.
    logic w_en;
    logic w_out_hs;

    logic [31:0] w_mask;
    logic [31:0] w_value;
    logic        w_err;

    logic        r_s1_valid;
    logic [31:0] r_s1_base;
    logic [31:0] r_s1_mask;
    logic [31:0] r_s1_value;
    logic        r_s1_err;

    logic              r_o_valid;
    logic [31:0]       r_o_instr;
    logic              r_o_err;
    logic [ADDR_W-1:0] r_addr;
    logic              r_err_sticky;

    assign w_en     = !r_o_valid || bus.i_ready;
    assign w_out_hs = r_o_valid && bus.i_ready;

    imm_scatter u_scatter (
        .i_fmt   (bus.i_fmt),
        .i_imm   (bus.i_imm),
        .o_mask  (w_mask),
        .o_value (w_value),
        .o_err   (w_err)
    );

    // Stage 1: range check and scatter results.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1_valid <= 1'b0;
            r_s1_base  <= 32'h0;
            r_s1_mask  <= 32'h0;
            r_s1_value <= 32'h0;
            r_s1_err   <= 1'b0;
        end else if (bus.i_flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_en) begin
            r_s1_valid <= bus.i_valid;
            r_s1_base  <= bus.i_base;
            r_s1_mask  <= w_mask;
            r_s1_value <= w_value;
            r_s1_err   <= w_err;
        end
    end

    // Stage 2: merged instruction word. o_value is already zero outside the
    // mask, so a plain OR completes the merge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_o_valid <= 1'b0;
            r_o_instr <= 32'h0;
            r_o_err   <= 1'b0;
        end else if (bus.i_flush) begin
            r_o_valid <= 1'b0;
        end else if (w_en) begin
            r_o_valid <= r_s1_valid;
            r_o_instr <= (r_s1_base & ~r_s1_mask) | r_s1_value;
            r_o_err   <= r_s1_err;
        end
    end

    // Address counter and sticky error. A handshake coinciding with a flush
    // is not counted; the flush reloads the counter instead.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_addr       <= BASE_ADDR;
            r_err_sticky <= 1'b0;
        end else if (bus.i_flush) begin
            r_addr       <= BASE_ADDR;
        end else if (w_out_hs) begin
            r_addr <= r_addr + ADDR_W'(4);
            if (r_o_err) begin
                r_err_sticky <= 1'b1;
            end
        end
    end

    assign bus.o_ready      = w_en;
    assign bus.o_valid      = r_o_valid;
    assign bus.o_instr      = r_o_instr;
    assign bus.o_err        = r_o_err;
    assign bus.o_addr       = r_addr;
    assign bus.o_err_sticky = r_err_sticky;

endmodule : imm_encoder
`default_nettype wire

// File: tb/tb_imm_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_encoder
//  Description : Scoreboard bench for imm_encoder. Stimulus pushes the
//                hand-computed expected word/address/error when a beat is
//                accepted; a monitor pops and compares on every output
//                handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_encoder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imm_encoder_if #(.ADDR_W(32)) bus ();

    imm_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int popped = 0;
    int popped_before;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: one sample per cycle, well after the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual 0x%08h @0x%08h required no beat",
                             bus.o_instr, bus.o_addr);
                end else begin
                    mon_e = q.pop_front();
                    chk("beat_instr", bus.o_instr, mon_e.instr);
                    chk("beat_addr", bus.o_addr, mon_e.addr);
                    chk("beat_err", {31'b0, bus.o_err}, {31'b0, mon_e.err});
                    popped++;
                end
            end
        end
    end

    task automatic send(input logic [31:0] base, input logic [31:0] imm,
                        input logic [2:0] fmt, input logic [31:0] exp_instr,
                        input logic [31:0] exp_addr, input logic exp_err);
        int w;
        exp_t e;
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_base  = base;
        bus.i_imm   = imm;
        bus.i_fmt   = fmt;
        #1;
        w = 0;
        while (bus.o_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (w >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual o_ready=%0b required 1", bus.o_ready);
            bus.i_valid = 1'b0;
            return;
        end
        e.instr = exp_instr;
        e.addr  = exp_addr;
        e.err   = exp_err;
        q.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (q.size() != 0 && w < 100) begin
            @(posedge clk);
            w++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual %0d pending required 0", q.size());
            q.delete();
        end
        @(negedge clk);
        #1;
    endtask

    task automatic do_flush();
        @(negedge clk);
        bus.i_flush = 1'b1;
        bus.i_valid = 1'b0;
        q.delete();
        @(negedge clk);
        bus.i_flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_base  = 32'h0;
        bus.i_imm   = 32'h0;
        bus.i_fmt   = 3'b000;
        bus.i_flush = 1'b0;
        bus.i_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready",  {31'b0, bus.o_ready},      32'd1);
        chk("rst_valid",  {31'b0, bus.o_valid},      32'd0);
        chk("rst_instr",  bus.o_instr,               32'h0);
        chk("rst_err",    {31'b0, bus.o_err},        32'd0);
        chk("rst_sticky", {31'b0, bus.o_err_sticky}, 32'd0);
        chk("rst_addr",   bus.o_addr,                32'h0);

        // I-type, latency.
        send(32'h0000_0093, 32'hFFFF_FFFF, 3'b000, 32'hFFF0_0093, 32'h0, 1'b0);
        @(negedge clk);
        bus.i_valid = 1'b0;
        #1;
        chk("lat_edge1", {31'b0, bus.o_valid}, 32'd0);
        @(negedge clk);
        #1;
        chk("lat_edge2", {31'b0, bus.o_valid}, 32'd1);
        drain();

        // S then B back to back from a reloaded counter.
        do_flush();
        send(32'h0020_A023, 32'h0000_0008, 3'b010, 32'h0020_A423, 32'h0, 1'b0);
        send(32'h0000_0063, 32'hFFFF_FFFC, 3'b011, 32'hFE00_0EE3, 32'h4, 1'b0);
        // J and U.
        send(32'h0000_00EF, 32'h0000_0800, 3'b100, 32'h0010_00EF, 32'h8, 1'b0);
        send(32'h0000_02B7, 32'h1234_5000, 3'b101, 32'h1234_52B7, 32'hC, 1'b0);
        idle();
        drain();
        chk("sticky_clean", {31'b0, bus.o_err_sticky}, 32'd0);

        // Range errors.
        send(32'h0000_0093, 32'h0000_0800, 3'b000, 32'h8000_0093, 32'h10, 1'b1);
        idle();
        drain();
        chk("sticky_set", {31'b0, bus.o_err_sticky}, 32'd1);
        send(32'h0000_0063, 32'h0000_0003, 3'b011, 32'h0000_0163, 32'h14, 1'b1);
        send(32'h0000_0093, 32'h0000_0005, 3'b111, 32'h0050_0093, 32'h18, 1'b1);
        idle();
        drain();

        // Backpressure: three beats offered while downstream stalls.
        do_flush();
        bus.i_ready   = 1'b0;
        popped_before = popped;
        fork
            begin
                send(32'h0000_0013, 32'h1, 3'b000, 32'h0010_0013, 32'h0, 1'b0);
                send(32'h0000_0013, 32'h2, 3'b000, 32'h0020_0013, 32'h4, 1'b0);
                send(32'h0000_0013, 32'h3, 3'b000, 32'h0030_0013, 32'h8, 1'b0);
                idle();
            end
            begin
                repeat (3) @(negedge clk);
                for (int i = 0; i < 5; i++) begin
                    #1;
                    chk("stall_valid", {31'b0, bus.o_valid}, 32'd1);
                    chk("stall_ready", {31'b0, bus.o_ready}, 32'd0);
                    chk("stall_instr", bus.o_instr, 32'h0010_0013);
                    chk("stall_addr",  bus.o_addr,  32'h0);
                    @(negedge clk);
                end
                bus.i_ready = 1'b1;
            end
        join
        drain();
        chk("stall_beats", popped - popped_before, 32'd3);

        // Flush with two beats in flight; a same-cycle beat is discarded.
        bus.i_ready = 1'b0;
        send(32'h0000_0013, 32'h7, 3'b000, 32'h0070_0013, 32'hC, 1'b0);
        send(32'h0000_0013, 32'h8, 3'b000, 32'h0080_0013, 32'h10, 1'b0);
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_imm   = 32'h9;
        bus.i_flush = 1'b1;
        q.delete();
        @(negedge clk);
        bus.i_flush = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        #1;
        chk("flush_valid",  {31'b0, bus.o_valid},      32'd0);
        chk("flush_addr",   bus.o_addr,                32'h0);
        chk("flush_sticky", {31'b0, bus.o_err_sticky}, 32'd1);
        @(negedge clk);
        #1;
        chk("flush_s1_clr", {31'b0, bus.o_valid}, 32'd0);
        send(32'h0000_0013, 32'h4, 3'b001, 32'h0040_0013, 32'h0, 1'b0);
        idle();
        drain();

        // Reset mid-stream.
        bus.i_ready = 1'b0;
        send(32'h0000_0013, 32'h5, 3'b000, 32'h0050_0013, 32'h4, 1'b0);
        send(32'h0000_0013, 32'h6, 3'b000, 32'h0060_0013, 32'h8, 1'b0);
        @(negedge clk);
        bus.i_valid = 1'b0;
        #1;
        chk("pre_rst_instr", bus.o_instr, 32'h0050_0013);
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        bus.i_ready = 1'b1;
        #1;
        chk("mid_rst_valid",  {31'b0, bus.o_valid},      32'd0);
        chk("mid_rst_instr",  bus.o_instr,               32'h0);
        chk("mid_rst_err",    {31'b0, bus.o_err},        32'd0);
        chk("mid_rst_sticky", {31'b0, bus.o_err_sticky}, 32'd0);
        chk("mid_rst_addr",   bus.o_addr,                32'h0);
        chk("mid_rst_ready",  {31'b0, bus.o_ready},      32'd1);
        repeat (3) @(negedge clk);
        #1;
        chk("end_queue", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_imm_encoder
`default_nettype wire

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Streaming RV32I immediate encoder. Inverse of the immediate decode path: takes a base instruction word, a 32-bit immediate value and a format code, and scatters the immediate into the format's bit positions.
- Checks that the immediate fits the format and flags it if not.
- Emits encoded words with a running word address. Used by the instruction-memory loader and by self-checking benches that build programs on the fly.
- Two-stage pipeline with valid/ready handshakes on both sides.

Parameters:
- ADDR_W, 32, width of the output address counter.
- BASE_ADDR, 32'h0000_0000, address of the first emitted word; must be 4-byte aligned.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge
- i_reset  input  1  synchronous reset, active-high
- i_valid  input  1  input beat valid
- o_ready  output  1  encoder can accept an input beat
- i_base  input  32  instruction with opcode/rd/rs1/rs2/funct fields set; bits in the selected format's immediate positions are ignored
- i_imm  input  32  immediate value (two's complement)
- i_fmt  input  3  000 I, 001 I-shamt, 010 S, 011 B, 100 J, 101 U, 110/111 reserved
- i_flush  input  1  drop all in-flight beats and reload the address counter
- o_valid  output  1  output beat valid
- i_ready  input  1  downstream accepts the output beat
- o_instr  output  32  encoded instruction
- o_addr  output  ADDR_W  byte address of o_instr
- o_err  output  1  range/format error for the current o_instr beat
- o_err_sticky  output  1  set on any accepted errored output; cleared only by reset

Behaviour:
- Reset (i_reset=1 at clock edge):
  - All valids are 0; o_instr=0; o_err=0; o_err_sticky=0.
  - Address counter = BASE_ADDR.
  - o_ready=1 in the first cycle after reset.
- Pipeline enable: en = !o_valid || i_ready; o_ready = en (combinational).
  - Input handshake: i_valid && o_ready. Output handshake: o_valid && i_ready.
- Stage 1, on en:
  - Captures s1_valid = i_valid.
  - Computes the range error and the scattered immediate field mask/value.
- Stage 2, on en: registers o_instr, o_err and o_valid = s1_valid.
- Latency: 2 cycles from input handshake to o_valid under no backpressure. Throughput: 1 beat per cycle.
- Stall rule: while o_valid && !i_ready, every stage holds and o_instr/o_addr/o_err stay stable.
- Bit placement (all non-immediate bits pass through from i_base):
  - I: [31:20] = imm[11:0].
  - I-shamt: [24:20] = imm[4:0]; [31:25] taken from i_base.
  - S: [31:25] = imm[11:5]; [11:7] = imm[4:0].
  - B: [31] = imm[12]; [30:25] = imm[10:5]; [11:8] = imm[4:1]; [7] = imm[11].
  - J: [31] = imm[20]; [30:21] = imm[10:1]; [20] = imm[11]; [19:12] = imm[19:12].
  - U: [31:12] = imm[31:12].
- Range error (o_err=1):
  - I and S: imm outside [-2048, 2047].
  - I-shamt: imm[31:5] != 0.
  - B: outside [-4096, 4094], or imm[0]=1.
  - J: outside [-1048576, 1048574], or imm[0]=1.
  - U: imm[11:0] != 0.
  - Reserved fmt: always an error; the I placement is used.
  - On error the field is still filled with the truncated bits as listed; the beat is not dropped.
- Address:
  - o_addr is the counter value.
  - Counter increments by 4 on each output handshake and wraps modulo 2^ADDR_W.
  - o_err_sticky is set on each output handshake with o_err=1.
- Flush (i_flush=1 at clock edge):
  - s1_valid and o_valid are cleared; counter reloads to BASE_ADDR; o_err_sticky is unchanged.
  - A same-cycle input handshake is discarded. A same-cycle output handshake does not increment the counter.
  - Reset has priority over flush.

Decomposition:
- Shared package rv_imm_pkg:
  - Typedef imm_fmt_e (I, I_SHAMT, S, B, J, U), matching the codes already used by immediate decode.
  - Range-limit localparams.
- One combinational sub-module imm_scatter: fmt + imm in; field mask, field value and err out. Reusable for a later assembler-side check.

Test Plan:
- I: base 0x00000093, imm 0xFFFFFFFF, fmt 000 -> o_instr 0xFFF00093, o_err 0, o_addr 0x0, o_valid exactly 2 cycles after the input handshake.
- S then B streamed back to back with i_ready=1:
  - base 0x0020A023, imm 8 -> 0x0020A423 @ addr 0x0.
  - base 0x00000063, imm 0xFFFFFFFC -> 0xFE000EE3 @ addr 0x4.
- J and U:
  - base 0x000000EF, imm 0x800, fmt 100 -> 0x001000EF.
  - base 0x000002B7, imm 0x12345000, fmt 101 -> 0x123452B7.
- Range errors:
  - I imm 2048 -> 0x80000093, o_err 1, o_err_sticky 1 after the handshake.
  - B imm 3 -> o_err 1.
  - Reserved fmt 111 -> o_err 1.
- Backpressure:
  - Hold i_ready=0 for 5 cycles with 3 beats offered -> o_ready drops once both stages are full; o_instr/o_addr stable while stalled.
  - All 3 beats delivered in order, addrs 0x0/0x4/0x8, none lost or duplicated.
- Flush and reset: i_flush with 2 beats in flight -> o_valid 0 next cycle, next emitted addr = BASE_ADDR; i_reset mid-stream -> all outputs return to reset values next cycle.
